// File: rtl/dmem_responder.sv
// Data-memory responder: arbitrates core and external ports, inserts wait states, acks with read data.
// Optional DMEM_RESPONDER_ERR_EN adds core_err/ext_err and suppresses out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [29:0] ADDR_BASE   = 30'h0
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [29:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_mask,
  input  logic        core_lock,
  output logic        core_ack,
  output logic [31:0] core_rdata,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [29:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_mask,
  output logic        ext_ack,
  output logic [31:0] ext_rdata,
  output logic        lock_held,
  output logic        busy
`ifdef DMEM_RESPONDER_ERR_EN
  ,
  output logic        core_err,
  output logic        ext_err
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
  typedef enum logic {G_CORE, G_EXT} grant_t;

  state_t      state, next_state;
  grant_t      last_grant, lat_grant, sel;
  logic        lat_we, lat_lock;
  logic [29:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_mask;
  logic [3:0]  wait_cnt;
  logic        ext_ok, grant_valid;
  logic [29:0] idx_full;
  logic [AW-1:0] idx;
  logic        in_range;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH];

  // While the core holds the lock the external port is invisible to arbitration.
  always_comb begin
    ext_ok      = ext_req & ~lock_held;
    grant_valid = core_req | ext_ok;
    sel         = G_EXT;
    if (core_req && ext_ok) sel = (last_grant == G_CORE) ? G_EXT : G_CORE;
    else if (core_req)      sel = G_CORE;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (grant_valid) next_state = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wait_cnt == 4'd0) next_state = S_ACCESS;
      S_ACCESS: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) state <= S_IDLE;
    else              state <= next_state;
  end

  assign busy     = (state != S_IDLE);
  assign idx_full = lat_addr - ADDR_BASE;
  assign idx      = idx_full[AW-1:0];

`ifdef DMEM_RESPONDER_ERR_EN
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  assign in_range = (idx_full < DEPTH_W);
`else
  // Without error reporting the index wraps modulo DEPTH; upper bits are dropped.
  logic unused_idx_hi;
  assign unused_idx_hi = ^idx_full[29:AW];
  assign in_range      = 1'b1;
`endif

  assign rd_word = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (state == S_ACCESS && lat_we && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lat_mask[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      last_grant <= G_EXT;
      lat_grant  <= G_CORE;
      lat_we     <= 1'b0;
      lat_lock   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mask   <= '0;
      wait_cnt   <= '0;
      core_ack   <= 1'b0;
      ext_ack    <= 1'b0;
      core_rdata <= '0;
      ext_rdata  <= '0;
      lock_held  <= 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
      core_err   <= 1'b0;
      ext_err    <= 1'b0;
`endif
    end else begin
      core_ack <= 1'b0;
      ext_ack  <= 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
      core_err <= 1'b0;
      ext_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            lat_grant  <= sel;
            last_grant <= sel;
            wait_cnt   <= WAIT_LOAD;
            if (sel == G_CORE) begin
              lat_we    <= core_we;
              lat_addr  <= core_addr;
              lat_wdata <= core_wdata;
              lat_mask  <= core_mask;
              lat_lock  <= core_lock;
            end else begin
              lat_we    <= ext_we;
              lat_addr  <= ext_addr;
              lat_wdata <= ext_wdata;
              lat_mask  <= ext_mask;
              lat_lock  <= 1'b0;
            end
          end
        end
        S_WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        S_ACCESS: begin
          if (lat_grant == G_CORE) begin
            core_ack  <= 1'b1;
            lock_held <= lat_lock;
            if (!lat_we) core_rdata <= rd_word;
`ifdef DMEM_RESPONDER_ERR_EN
            core_err  <= ~in_range;
`endif
          end else begin
            ext_ack <= 1'b1;
            if (!lat_we) ext_rdata <= rd_word;
`ifdef DMEM_RESPONDER_ERR_EN
            ext_err <= ~in_range;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, WAIT_STATES=1).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        core_req, core_we, core_lock;
  logic [29:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_mask;
  logic        core_ack;
  logic [31:0] core_rdata;
  logic        ext_req, ext_we;
  logic [29:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_mask;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        lock_held, busy;
  logic        core_err_s, ext_err_s;

  int total = 0;
  int bad   = 0;
  int core_acks = 0;
  int ext_acks  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(1), .ADDR_BASE(30'h0)) dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_mask(core_mask), .core_lock(core_lock), .core_ack(core_ack), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_mask(ext_mask), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .lock_held(lock_held), .busy(busy)
`ifdef DMEM_RESPONDER_ERR_EN
    , .core_err(core_err_s), .ext_err(ext_err_s)
`endif
  );

`ifndef DMEM_RESPONDER_ERR_EN
  assign core_err_s = 1'b0;
  assign ext_err_s  = 1'b0;
`endif

  always @(negedge clk) begin
    if (core_ack) core_acks <= core_acks + 1;
    if (ext_ack)  ext_acks  <= ext_acks + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    async_rst_n = 1'b0;
    tick();
    tick();
    async_rst_n = 1'b1;
    tick();
  endtask

  // Issues one core access and returns in the ack cycle with req already dropped.
  task automatic do_core(input logic we, input logic [29:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic lock,
                         output logic [31:0] rd, output int lat, output logic err);
    core_we = we; core_addr = addr; core_wdata = wdata; core_mask = mask; core_lock = lock;
    core_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!core_ack && lat < 40);
    if (!core_ack) lat = -1;
    rd  = core_rdata;
    err = core_err_s;
    core_req = 1'b0;
  endtask

  task automatic test_reset();
    async_rst_n = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_mask = '0; core_lock = 0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_mask = '0;
    tick();
    tick();
    total++; if (core_ack !== 1'b0) begin bad++; $display("FAIL rst_core_ack got=%b exp=0", core_ack); end
    total++; if (ext_ack !== 1'b0) begin bad++; $display("FAIL rst_ext_ack got=%b exp=0", ext_ack); end
    total++; if (lock_held !== 1'b0) begin bad++; $display("FAIL rst_lock got=%b exp=0", lock_held); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL rst_core_rdata got=%h exp=0", core_rdata); end
    total++; if (ext_rdata !== 32'h0) begin bad++; $display("FAIL rst_ext_rdata got=%h exp=0", ext_rdata); end
    async_rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [31:0] rd; int lat; logic er;
    do_core(1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_keeps_rdata got=%h exp=0", rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ack_cycle_idle busy=%b exp=0", busy); end
    do_core(1'b0, 30'h10, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_mask();
    logic [31:0] rd; int lat; logic er;
    do_core(1'b1, 30'h11, 32'h11223344, 4'hF, 1'b0, rd, lat, er);
    do_core(1'b1, 30'h11, 32'hAABBCCDD, 4'b0101, 1'b0, rd, lat, er);
    do_core(1'b0, 30'h11, 32'h0, 4'h0, 1'b0, rd, lat, er);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL mask_merge got=%h exp=11bb33dd", rd); end
    do_core(1'b1, 30'h11, 32'hFFFFFFFF, 4'h0, 1'b0, rd, lat, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL mask0_ack lat got=%0d exp=3", lat); end
    do_core(1'b0, 30'h11, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL mask0_noop got=%h exp=11bb33dd", rd); end
    do_core(1'b1, 30'h3FF, 32'h600DCAFE, 4'hF, 1'b0, rd, lat, er);
    do_core(1'b0, 30'h3FF, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (rd !== 32'h600DCAFE) begin bad++; $display("FAIL last_index got=%h exp=600dcafe", rd); end
  endtask

  task automatic test_round_robin();
    logic [15:0] seq_word, pos_word;
    int n;
    logic both;
    apply_reset();
    seq_word = '0; pos_word = '0; n = 0; both = 1'b0;
    core_we = 0; core_addr = 30'h10; core_mask = 4'hF; core_lock = 0;
    ext_we = 0; ext_addr = 30'h11; ext_mask = 4'hF;
    core_req = 1'b1; ext_req = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (core_ack && ext_ack) both = 1'b1;
      if (core_ack || ext_ack) begin
        seq_word = {seq_word[11:0], core_ack ? 4'h1 : 4'h2};
        pos_word = {pos_word[11:0], 4'(t)};
        n++;
      end
    end
    core_req = 1'b0; ext_req = 1'b0;
    total++; if (n !== 4) begin bad++; $display("FAIL rr_ack_count got=%0d exp=4", n); end
    total++; if (seq_word !== 16'h1212) begin bad++; $display("FAIL rr_order got=%h exp=1212", seq_word); end
    total++; if (pos_word !== 16'h369C) begin bad++; $display("FAIL rr_ack_cycles got=%h exp=369c", pos_word); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL rr_dual_ack got=%b exp=0", both); end
    total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rr_core_rdata got=%h exp=deadbeef", core_rdata); end
    total++; if (ext_rdata !== 32'h11BB33DD) begin bad++; $display("FAIL rr_ext_rdata got=%h exp=11bb33dd", ext_rdata); end
  endtask

  task automatic test_lock();
    logic [31:0] rd; int lat; logic er; int e0;
    tick();
    do_core(1'b0, 30'h10, 32'h0, 4'hF, 1'b1, rd, lat, er);
    total++; if (lock_held !== 1'b1) begin bad++; $display("FAIL lock_set got=%b exp=1", lock_held); end
    ext_we = 0; ext_addr = 30'h10; ext_mask = 4'hF; ext_req = 1'b1;
    e0 = ext_acks;
    do_core(1'b0, 30'h11, 32'h0, 4'hF, 1'b1, rd, lat, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL lock_core_lat got=%0d exp=3", lat); end
    do_core(1'b0, 30'h11, 32'h0, 4'hF, 1'b1, rd, lat, er);
    total++; if (lock_held !== 1'b1) begin bad++; $display("FAIL lock_kept got=%b exp=1", lock_held); end
    total++; if (ext_acks !== e0) begin bad++; $display("FAIL lock_blocks_ext acks=%0d exp=%0d", ext_acks, e0); end
    do_core(1'b0, 30'h10, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (lock_held !== 1'b0) begin bad++; $display("FAIL lock_release got=%b exp=0", lock_held); end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ext_ack && lat < 10);
    ext_req = 1'b0;
    total++; if (lat !== 3) begin bad++; $display("FAIL ext_after_unlock lat=%0d exp=3", lat); end
    total++; if (ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ext_rdata got=%h exp=deadbeef", ext_rdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic er; int c0;
    do_core(1'b1, 30'h20, 32'h12345678, 4'hF, 1'b0, rd, lat, er);
    core_we = 1; core_addr = 30'h20; core_wdata = 32'hCAFEF00D; core_mask = 4'hF; core_lock = 0;
    core_req = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    c0 = core_acks;
    async_rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after_rst got=%b exp=0", busy); end
    core_req = 1'b0;
    tick();
    tick();
    async_rst_n = 1'b1;
    tick();
    tick();
    tick();
    total++; if (core_acks !== c0) begin bad++; $display("FAIL mid_no_ack acks=%0d exp=%0d", core_acks, c0); end
    do_core(1'b0, 30'h20, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL mid_read_lat got=%0d exp=3", lat); end
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL mid_write_dropped got=%h exp=12345678", rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd; int lat; logic er;
    do_core(1'b1, 30'h0, 32'h01020304, 4'hF, 1'b0, rd, lat, er);
    do_core(1'b1, 30'h400, 32'hA5A55A5A, 4'hF, 1'b0, rd, lat, er);
    total++; if (lat !== 3) begin bad++; $display("FAIL oor_write_lat got=%0d exp=3", lat); end
`ifdef DMEM_RESPONDER_ERR_EN
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_write_err got=%b exp=1", er); end
    do_core(1'b0, 30'h400, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_read_err got=%b exp=1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_read_data got=%h exp=0", rd); end
    do_core(1'b0, 30'h0, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL inrange_err got=%b exp=0", er); end
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL oor_write_suppressed got=%h exp=01020304", rd); end
`else
    do_core(1'b0, 30'h0, 32'h0, 4'hF, 1'b0, rd, lat, er);
    total++; if (rd !== 32'hA5A55A5A) begin bad++; $display("FAIL alias_idx0 got=%h exp=a5a55a5a", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
